// File: rtl/loader_pkg.sv
// Package for the serial RAM boot loader.
//   state_t     : loader FSM states
//   RAM_TOP     : highest writable RAM address
//   HDR_LEN     : header bytes following the sync byte (addr_lo, addr_hi, len_lo, len_hi)
//   SYNC_DEFAULT: default frame start marker
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CSUM  = 3'd4
   } state_t;

   localparam logic [15:0] RAM_TOP      = 16'h7FFF;
   localparam int          HDR_LEN      = 4;
   localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/ram_loader.sv
// Serial-to-memory boot loader. Takes a framed byte stream from the UART,
// halts the CPU, writes the payload into RAM (0x0000-0x7FFF) as bus master,
// then validates the trailing checksum.
// Ports:
//   mem_clk    system clock shared with the RAM
//   rst_n      synchronous active-low reset
//   rx_data    byte from UART, qualified by rx_valid
//   rx_ready   loader accepts a byte (transfer on rx_valid & rx_ready)
//   cpu_halt   request the CPU off the bus
//   bus_grant  CPU has released the bus
//   addr/RW    bus address / read-write, driven only while granted, else Z
//   data       bus data, driven only in WRITE while granted, else Z
//   done       one-cycle pulse: frame loaded and checksum good
//   err        sticky error, cleared by the next sync byte or reset
module ram_loader
   import loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic        mem_clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        cpu_halt,
   input  logic        bus_grant,
   output logic [15:0] addr,
   inout  wire  [7:0]  data,
   output logic        RW,
   output logic        done,
   output logic        err
);

   // base + len may land exactly on the first address past RAM
   localparam logic [16:0] LIMIT    = {1'b0, RAM_TOP} + 17'd1;
   localparam logic [1:0]  HDR_LAST = 2'(HDR_LEN - 1);

   state_t      state, state_nxt;
   logic        rdy_dec;
   logic        rx_fire;
   logic [1:0]  hdr_cnt;
   logic [15:0] base;
   logic [7:0]  len_lo;
   logic [15:0] hdr_len;
   logic        hdr_end;
   logic        range_bad;
   logic [14:0] ptr;
   logic [15:0] remaining;
   logic [7:0]  wbuf;
   logic [7:0]  sum;
   logic [7:0]  sum_chk;
   logic        wr_cyc;

   // ready is a pure state decode, forced low while reset is held
   always_comb begin
      rdy_dec = 1'b0;
      case (state)
         IDLE, HDR, DATA, CSUM: rdy_dec = 1'b1;
         default:               rdy_dec = 1'b0;
      endcase
   end

   assign rx_ready = rst_n & rdy_dec;
   assign rx_fire  = rx_valid & rx_ready;

   // len_hi arrives on the last header byte, so the length is assembled
   // from the live byte and the range check is done before anything is stored
   assign hdr_len   = {rx_data, len_lo};
   assign hdr_end   = rx_fire && (state == HDR) && (hdr_cnt == HDR_LAST);
   assign range_bad = base[15] || (({1'b0, base} + {1'b0, hdr_len}) > LIMIT);
   assign sum_chk   = sum + rx_data;
   assign wr_cyc    = (state == WRITE) && bus_grant;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge mem_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (rx_fire && rx_data == SYNC_BYTE) state_nxt = HDR;
         HDR: begin
            if (hdr_end) begin
               if (range_bad)          state_nxt = IDLE;
               else if (hdr_len == '0) state_nxt = CSUM;
               else                    state_nxt = DATA;
            end
         end
         DATA:  if (rx_fire) state_nxt = WRITE;
         WRITE: begin
            // without grant the state simply holds and the write retries
            if (bus_grant) state_nxt = (remaining == 16'd1) ? CSUM : DATA;
         end
         CSUM:  if (rx_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         hdr_cnt   <= '0;
         base      <= '0;
         len_lo    <= '0;
         ptr       <= '0;
         remaining <= '0;
         wbuf      <= '0;
         sum       <= '0;
         cpu_halt  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_fire && rx_data == SYNC_BYTE) begin
                  err     <= 1'b0;
                  hdr_cnt <= '0;
                  sum     <= '0;
               end
            end
            HDR: begin
               if (rx_fire) begin
                  hdr_cnt <= hdr_cnt + 2'd1;
                  case (hdr_cnt)
                     2'd0:    base[7:0]  <= rx_data;
                     2'd1:    base[15:8] <= rx_data;
                     2'd2:    len_lo     <= rx_data;
                     default: begin
                        if (range_bad) begin
                           err <= 1'b1;
                        end else begin
                           ptr       <= base[14:0];
                           remaining <= hdr_len;
                           // empty frames never need the bus
                           if (hdr_len != '0) cpu_halt <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            DATA: begin
               if (rx_fire) begin
                  wbuf <= rx_data;
                  sum  <= sum + rx_data;
               end
            end
            WRITE: begin
               if (bus_grant) begin
                  ptr       <= ptr + 15'd1;
                  remaining <= remaining - 16'd1;
               end
            end
            CSUM: begin
               if (rx_fire) begin
                  if (sum_chk == 8'h00) done <= 1'b1;
                  else                  err  <= 1'b1;
                  cpu_halt <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------- bus drivers
   // Grant gates everything combinationally so a lost grant releases the
   // bus in the same cycle.
   assign addr = bus_grant ? {1'b0, ptr} : 16'hzzzz;
   assign RW   = bus_grant ? ~wr_cyc     : 1'bz;
   assign data = wr_cyc    ? wbuf        : 8'hzz;

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

   logic        mem_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        cpu_halt;
   logic        bus_grant = 1'b1;
   logic [15:0] addr;
   wire  [7:0]  data;
   logic        RW;
   logic        done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   // RAM model and bus observers
   logic [7:0]  mem [0:32767];
   int          wr_cnt   = 0;
   int          done_cnt = 0;
   logic [15:0] last_wa  = 16'h0;
   logic [7:0]  last_wd  = 8'h0;

   ram_loader dut (
      .mem_clk  (mem_clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .cpu_halt (cpu_halt),
      .bus_grant(bus_grant),
      .addr     (addr),
      .data     (data),
      .RW       (RW),
      .done     (done),
      .err      (err)
   );

   always #5 mem_clk = ~mem_clk;

   always @(posedge mem_clk) begin
      if (bus_grant && RW === 1'b0 && addr[15] === 1'b0) begin
         mem[addr[14:0]] <= data;
         wr_cnt  <= wr_cnt + 1;
         last_wa <= addr;
         last_wd <= data;
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic send(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      @(negedge mem_clk);
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(posedge mem_clk);
         if (rx_ready === 1'b1) ok = 1'b1;
      end
      #1 rx_valid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL send_timeout byte=%h not accepted within 50 cycles", b);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge mem_clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle(3);
      n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
      n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_halt got=%b exp=0", cpu_halt); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
      n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
      rst_n = 1'b1;
      idle(1);
      n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_rx_ready got=%b exp=1", rx_ready); end
   endtask

   task automatic test_good_frame;
      int d0, w0;
      d0 = done_cnt; w0 = wr_cnt;
      send(8'hA5); send(8'h00); send(8'h02); send(8'h03); send(8'h00);
      n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("FAIL good_halt_hdr got=%b exp=1", cpu_halt); end
      send(8'h11);
      send(8'h22);
      n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("FAIL good_halt_mid got=%b exp=1", cpu_halt); end
      send(8'h33);
      send(8'h9A);
      idle(3);
      n_cmp++; if (mem[16'h0200] !== 8'h11) begin n_bad++; $display("FAIL good_m0 got=%h exp=11", mem[16'h0200]); end
      n_cmp++; if (mem[16'h0201] !== 8'h22) begin n_bad++; $display("FAIL good_m1 got=%h exp=22", mem[16'h0201]); end
      n_cmp++; if (mem[16'h0202] !== 8'h33) begin n_bad++; $display("FAIL good_m2 got=%h exp=33", mem[16'h0202]); end
      n_cmp++; if (wr_cnt - w0 != 3)        begin n_bad++; $display("FAIL good_wr_cnt got=%0d exp=3", wr_cnt - w0); end
      n_cmp++; if (done_cnt - d0 != 1)      begin n_bad++; $display("FAIL good_done got=%0d exp=1", done_cnt - d0); end
      n_cmp++; if (err !== 1'b0)            begin n_bad++; $display("FAIL good_err got=%b exp=0", err); end
      n_cmp++; if (cpu_halt !== 1'b0)       begin n_bad++; $display("FAIL good_halt_end got=%b exp=0", cpu_halt); end
   endtask

   task automatic test_bad_chk;
      int d0;
      d0 = done_cnt;
      send(8'hA5); send(8'h00); send(8'h03); send(8'h03); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h9B);
      idle(3);
      n_cmp++; if (mem[16'h0302] !== 8'h33) begin n_bad++; $display("FAIL bad_m2 got=%h exp=33", mem[16'h0302]); end
      n_cmp++; if (err !== 1'b1)            begin n_bad++; $display("FAIL bad_err got=%b exp=1", err); end
      n_cmp++; if (done_cnt != d0)          begin n_bad++; $display("FAIL bad_done got=%0d exp=%0d", done_cnt, d0); end
      n_cmp++; if (cpu_halt !== 1'b0)       begin n_bad++; $display("FAIL bad_halt got=%b exp=0", cpu_halt); end
   endtask

   task automatic test_range;
      int w0, d0;
      w0 = wr_cnt;
      send(8'hA5); send(8'hFE); send(8'h7F); send(8'h03); send(8'h00);
      n_cmp++; if (err !== 1'b1)      begin n_bad++; $display("FAIL range_err got=%b exp=1", err); end
      n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL range_halt got=%b exp=0", cpu_halt); end
      idle(4);
      n_cmp++; if (wr_cnt != w0)      begin n_bad++; $display("FAIL range_writes got=%0d exp=%0d", wr_cnt, w0); end
      // exactly reaching the top of RAM is legal
      d0 = done_cnt;
      send(8'hA5);
      n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL sync_clr_err got=%b exp=0", err); end
      send(8'hFE); send(8'h7F); send(8'h02); send(8'h00);
      send(8'hAA); send(8'hBB); send(8'h9B);
      idle(3);
      n_cmp++; if (mem[16'h7FFE] !== 8'hAA) begin n_bad++; $display("FAIL top_m0 got=%h exp=aa", mem[16'h7FFE]); end
      n_cmp++; if (mem[16'h7FFF] !== 8'hBB) begin n_bad++; $display("FAIL top_m1 got=%h exp=bb", mem[16'h7FFF]); end
      n_cmp++; if (done_cnt - d0 != 1)      begin n_bad++; $display("FAIL top_done got=%0d exp=1", done_cnt - d0); end
      n_cmp++; if (err !== 1'b0)            begin n_bad++; $display("FAIL top_err got=%b exp=0", err); end
   endtask

   task automatic test_grant_gap;
      int w0, d0;
      d0 = done_cnt;
      send(8'hA5); send(8'h00); send(8'h10); send(8'h03); send(8'h00);
      send(8'h01);
      send(8'h02);
      bus_grant = 1'b0;
      w0 = wr_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge mem_clk);
         n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL gap_rx_ready cyc=%0d got=%b exp=0", i, rx_ready); end
         n_cmp++; if (wr_cnt != w0)      begin n_bad++; $display("FAIL gap_no_write cyc=%0d got=%0d exp=%0d", i, wr_cnt, w0); end
      end
      bus_grant = 1'b1;
      idle(1);
      n_cmp++; if (wr_cnt != w0 + 1)     begin n_bad++; $display("FAIL gap_retry got=%0d exp=%0d", wr_cnt, w0 + 1); end
      n_cmp++; if (last_wa !== 16'h1001) begin n_bad++; $display("FAIL gap_addr got=%h exp=1001", last_wa); end
      n_cmp++; if (last_wd !== 8'h02)    begin n_bad++; $display("FAIL gap_data got=%h exp=02", last_wd); end
      send(8'h03); send(8'hFA);
      idle(3);
      n_cmp++; if (mem[16'h1002] !== 8'h03) begin n_bad++; $display("FAIL gap_m2 got=%h exp=03", mem[16'h1002]); end
      n_cmp++; if (done_cnt - d0 != 1)      begin n_bad++; $display("FAIL gap_done got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_len_zero;
      int w0, d0;
      w0 = wr_cnt; d0 = done_cnt;
      send(8'hA5); send(8'h00); send(8'h03); send(8'h00); send(8'h00);
      n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL zero_halt got=%b exp=0", cpu_halt); end
      send(8'h00);
      idle(3);
      n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL zero_done got=%0d exp=1", done_cnt - d0); end
      n_cmp++; if (wr_cnt != w0)       begin n_bad++; $display("FAIL zero_writes got=%0d exp=%0d", wr_cnt, w0); end
      n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL zero_err got=%b exp=0", err); end
   endtask

   task automatic test_reset_mid;
      int d0;
      send(8'hA5); send(8'h00); send(8'h04); send(8'h04); send(8'h00);
      send(8'h55); send(8'h66);
      rst_n = 1'b0;
      idle(2);
      n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL mid_halt got=%b exp=0", cpu_halt); end
      n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rx_ready got=%b exp=0", rx_ready); end
      n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL mid_err got=%b exp=0", err); end
      rst_n = 1'b1;
      idle(1);
      n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL mid_post_ready got=%b exp=1", rx_ready); end
      d0 = done_cnt;
      send(8'hA5); send(8'h00); send(8'h05); send(8'h01); send(8'h00);
      send(8'h77); send(8'h89);
      idle(3);
      n_cmp++; if (mem[16'h0500] !== 8'h77) begin n_bad++; $display("FAIL fresh_m0 got=%h exp=77", mem[16'h0500]); end
      n_cmp++; if (done_cnt - d0 != 1)      begin n_bad++; $display("FAIL fresh_done got=%0d exp=1", done_cnt - d0); end
      n_cmp++; if (cpu_halt !== 1'b0)       begin n_bad++; $display("FAIL fresh_halt got=%b exp=0", cpu_halt); end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
      test_reset;
      test_good_frame;
      test_bad_chk;
      test_range;
      test_grant_gap;
      test_len_zero;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_loader.md
# ram_loader

Serial-to-memory boot loader that sits directly upstream of the 32 KiB RAM on the shared 6502 address/data bus. It consumes a framed byte stream from the UART receiver, halts the CPU, and writes the payload into RAM at 0x0000–0x7FFF as a bus master. It then validates a trailing checksum and reports done or error. The RAM decodes `addr[15]=0`, drives `data` only when `RW=1`, and samples a write on the `mem_clk` edge while `RW=0`.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `mem_clk`  in  1  system clock, shared with RAM
- `rst_n`  in  1  synchronous, active-low reset
- `rx_data`  in  8  byte from UART receiver
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader accepts byte; a transfer occurs on an edge where `rx_valid & rx_ready`
- `cpu_halt`  out  1  request CPU off the bus
- `bus_grant`  in  1  CPU has released the bus (tri-stated `addr`/`data`/`RW`)
- `addr`  out  16  bus address, driven only while `bus_grant=1`, else Z
- `data`  inout  8  bus data, driven only in WRITE with `bus_grant=1`, else Z
- `RW`  out  1  1=read, 0=write; driven only while `bus_grant=1`, else Z
- `done`  out  1  one-cycle pulse: frame loaded, checksum good
- `err`  out  1  sticky error flag, cleared by the next sync byte or by reset

## Operation
- Frame format: `SYNC_BYTE`, addr_lo, addr_hi, len_lo, len_hi, then len payload bytes, then chk. The frame is good when the 8-bit sum of all payload bytes plus chk equals 8'h00.
- States:
  - IDLE: `rx_ready=1`. Bytes other than sync are dropped. A sync byte clears `err` and moves to HDR.
  - HDR: accepts 4 bytes into `base` and `len` (16 bits each). After the 4th byte:
    - if `base[15]=1` or `base+len > 17'h08000` (17-bit add): set `err`, go to IDLE, no writes;
    - else if `len=0`: go to CSUM;
    - else: assert `cpu_halt`, go to DATA.
  - DATA: `rx_ready=1`. An accepted byte is latched into `wbuf`, added to `sum`, and the state moves to WRITE.
  - WRITE: `rx_ready=0`. Waits for `bus_grant`. With grant, for exactly one cycle it drives `addr=ptr`, `data=wbuf`, `RW=0`. Then it increments `ptr` and decrements `remaining`. If `remaining` becomes 0 it goes to CSUM, else to DATA.
  - CSUM: accepts 1 byte. If `sum+byte == 0`, pulse `done`; else set `err`. Deassert `cpu_halt`. Go to IDLE.
- `ptr` is 15 bits plus `addr[15]=0`. The header check guarantees no wrap past 0x7FFF; `base+len == 0x8000` exactly is legal.
- `cpu_halt` stays high from the end of HDR until CSUM completes, including while a frame is in error. Payload of an errored frame may already be in RAM.
- While granted and not in WRITE, the loader drives `RW=1`, `addr=ptr`, `data` Z.

## Timing
- Reset (`rst_n=0` sampled on the edge) produces: IDLE, `rx_ready=0` during reset, `cpu_halt=0`, `done=0`, `err=0`, `addr`/`RW`/`data` Z, `sum=0`. The first cycle after reset, `rx_ready=1`.
- Reset mid-frame aborts immediately. `cpu_halt` drops on the same edge; no partial bus write is extended.
- `rx_ready` is a combinational decode of the state only. It never depends on `rx_valid`.
- Payload throughput is 2 cycles per byte with grant held. Each cycle without grant in WRITE adds one cycle.
- A grant lost during WRITE holds the state. Bus outputs go to Z that same cycle, and the write retries when grant returns.
- `done` is registered and asserted in the cycle after the chk byte is accepted.

## Structure
- Package `loader_pkg`: state enum (IDLE, HDR, DATA, WRITE, CSUM), `RAM_TOP=16'h7FFF`, `HDR_LEN=4`.
- Single module, no sub-modules. Tri-state drivers are continuous assigns gated by `bus_grant`, plus the state term for `data`.

## Test plan
- Load A5 00 02 03 00 11 22 33 9A with grant tied high -> RAM[0x0200..0x0202]=11,22,33; `done` pulses once; `err=0`; `cpu_halt` high throughout the payload.
- Same frame with chk 9B -> RAM written; `err=1` and `done=0`; `cpu_halt` released.
- Header addr 7FFE, len 0003 -> `err=1` after len_hi; no `RW=0` cycle; `cpu_halt` never asserted. Addr 7FFE, len 0002 -> accepted, writes to 7FFE and 7FFF.
- `bus_grant` low for 5 cycles during the 2nd write -> `rx_ready=0` and buses Z; the write occurs after grant with the correct addr/data.
- `len=0`, chk 00 -> `done` pulses with no bus activity.
- Reset asserted mid-payload, then a fresh frame -> all outputs at reset values and the new frame loads correctly.
